// File: rtl/mdu_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU unit.
package mdu_pkg;

  localparam int DIV_WIDTH = 32;

  // Quotient reported for any divide by zero, signed or unsigned.
  localparam logic [DIV_WIDTH-1:0] DIV_BYZERO_QUO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring division iteration: shift {rem,quo} left, trial-subtract, restore on borrow.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] diff;

  // The shifted remainder needs one extra bit; the difference always fits when it is kept.
  always_comb begin
    remShift = {rem_i, quo_i[WIDTH-1]};
    diff     = remShift[WIDTH-1:0] - divisor_i;
    if (remShift >= {1'b0, divisor_i}) begin
      rem_o = diff;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = remShift[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_div_unit.sv
// Multi-cycle signed/unsigned divider beside the EX-stage ALU; stalls F/D/EX while busy.
// Optional MDU_DIV_EARLY_EXIT_EN: finish in one cycle when |a| < |b| and b != 0.
module mdu_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_req_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quoOut_q, quoOut_d, remOut_q, remOut_d;
  logic             sgn_q, sgn_d, aSign_q, aSign_d, bSign_q, bSign_d;
  logic             byZero_q, byZero_d;

  logic [WIDTH-1:0] absA, absB, stepRem, stepQuo;
  logic             negQ, negR;

  assign absA = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign absB = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  assign negQ = sgn_q & (aSign_q ^ bSign_q);
  assign negR = sgn_q & aSign_q;

  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (stepRem),
    .quo_o     (stepQuo)
  );

  // A flush leaves every register untouched except the state, so held results survive it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    quoOut_d = quoOut_q;
    remOut_d = remOut_q;
    sgn_d    = sgn_q;
    aSign_d  = aSign_q;
    bSign_d  = bSign_q;
    byZero_d = byZero_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d  = BUSY;
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = absA;
            dvsr_d   = absB;
            sgn_d    = signed_i;
            aSign_d  = a_i[WIDTH-1];
            bSign_d  = b_i[WIDTH-1];
            byZero_d = (b_i == '0);
`ifdef MDU_DIV_EARLY_EXIT_EN
            if ((b_i != '0) && (absA < absB)) begin
              state_d  = DONE;
              quoOut_d = '0;
              remOut_d = a_i;
            end
`endif
          end
        end
        BUSY: begin
          rem_d = stepRem;
          quo_d = stepQuo;
          cnt_d = cnt_q + 1'b1;
          // Divide by zero leaves rem=|a|, so the dividend-sign fix-up hands back a_i unchanged.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DONE;
            quoOut_d = byZero_q ? '1 : (negQ ? -stepQuo : stepQuo);
            remOut_d = negR ? -stepRem : stepRem;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      quoOut_q <= '0;
      remOut_q <= '0;
      sgn_q    <= 1'b0;
      aSign_q  <= 1'b0;
      bSign_q  <= 1'b0;
      byZero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      quoOut_q <= quoOut_d;
      remOut_q <= remOut_d;
      sgn_q    <= sgn_d;
      aSign_q  <= aSign_d;
      bSign_q  <= bSign_d;
      byZero_q <= byZero_d;
    end
  end

  assign stall_req_o = !flush_i && (((state_q == IDLE) && start_i) || (state_q == BUSY));
  assign valid_o     = (state_q == DONE);
  assign quo_o       = quoOut_q;
  assign rem_o       = remOut_q;

endmodule

// File: tb/tb_mdu_div_unit.sv
// Self-checking bench for mdu_div_unit: arithmetic/timing model plus literal expectations.
module tb_mdu_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_req_o;
  logic        valid_o;
  logic [31:0] quo_o;
  logic [31:0] rem_o;

  int nVec  = 0;
  int nFail = 0;

`ifdef MDU_DIV_EARLY_EXIT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  mdu_div_unit dut (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .stall_req_o (stall_req_o),
    .valid_o     (valid_o),
    .quo_o       (quo_o),
    .rem_o       (rem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: truncating division, remainder takes the dividend's sign.
  function automatic void modelDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = DIV_BYZERO_QUO;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  function automatic logic [31:0] magOf(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? -v : v;
  endfunction

  function automatic bit modelEarly(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_DIV_EARLY_EXIT_EN
    return (b != 32'd0) && (magOf(sgn, a) < magOf(sgn, b));
`else
    return (magOf(sgn, a) == 32'd0) && (magOf(sgn, b) == 32'd0) && 1'b0;
`endif
  endfunction

  // Model: mWait counts cycles until the result cycle; mDone marks the result cycle itself.
  int          mWait = 0;
  bit          mDone = 1'b0;
  logic [31:0] expQ  = 32'd0;
  logic [31:0] expR  = 32'd0;
  logic [31:0] pendQ, pendR;
  logic        expStall;

  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mWait = 0;
        mDone = 1'b0;
        expQ  = 32'd0;
        expR  = 32'd0;
      end
      expStall = !flush_i && ((mWait == 0 && !mDone && start_i) || mWait > 0);
      checkOutput("stall", {31'd0, stall_req_o}, {31'd0, expStall});
      checkOutput("valid", {31'd0, valid_o}, {31'd0, mDone});
      checkOutput("quo", quo_o, expQ);
      checkOutput("rem", rem_o, expR);
      if (resetn) begin
        if (flush_i) begin
          mWait = 0;
          mDone = 1'b0;
        end else if (mDone) begin
          mDone = 1'b0;
        end else if (mWait > 0) begin
          mWait--;
          if (mWait == 0) begin
            mDone = 1'b1;
            expQ  = pendQ;
            expR  = pendR;
          end
        end else if (start_i) begin
          modelDiv(signed_i, a_i, b_i, pendQ, pendR);
          if (modelEarly(signed_i, a_i, b_i)) begin
            mDone = 1'b1;
            expQ  = pendQ;
            expR  = pendR;
          end else begin
            mWait = 32;
          end
        end
      end
    end
  end

  // Holds start_i until the result cycle (as the pipeline does), then checks literal results.
  task automatic applyStimulus(input string name, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                               input int lat);
    int  k;
    bit  got;
    @(posedge clk);
    #1;
    start_i  = 1'b1;
    signed_i = sgn;
    a_i      = a;
    b_i      = b;
    k   = 0;
    got = 1'b0;
    while (!got && k < 100) begin
      @(negedge clk);
      if (valid_o) got = 1'b1;
      else k++;
    end
    checkOutput({name, " latency"}, 32'(k), 32'(lat));
    if (got) begin
      checkOutput({name, " quo"}, quo_o, q);
      checkOutput({name, " rem"}, rem_o, r);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    resetn   = 1'b0;
    start_i  = 1'b0;
    signed_i = 1'b0;
    a_i      = 32'd0;
    b_i      = 32'd0;
    flush_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    applyStimulus("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    applyStimulus("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    applyStimulus("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    applyStimulus("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    applyStimulus("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 33);
    applyStimulus("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 33);
    applyStimulus("divu 3/10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, EARLY_LAT);
    applyStimulus("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);

    // Flush at T+10 of a running divide, then a fresh DIVU 9/3 at T+12.
    @(posedge clk);
    #1;
    start_i  = 1'b1;
    signed_i = 1'b0;
    a_i      = 32'd100;
    b_i      = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    applyStimulus("divu 9/3 after flush", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk);
    #1;
    start_i  = 1'b1;
    signed_i = 1'b0;
    a_i      = 32'd1000;
    b_i      = 32'd3;
    repeat (5) @(posedge clk);
    #2;
    resetn  = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("reset stall", {31'd0, stall_req_o}, 32'd0);
    checkOutput("reset valid", {31'd0, valid_o}, 32'd0);
    checkOutput("reset quo", quo_o, 32'd0);
    checkOutput("reset rem", rem_o, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    applyStimulus("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
